// File: rtl/keypad_pkg.sv
// Shared types and key decoding for the matrix keypad front end.
package keypad_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StRelWait
    } kp_state_e;

    // Classification of one completed 16-key scan.
    typedef enum logic [1:0] {
        ClsNone,
        ClsSingle,
        ClsMulti
    } kp_class_e;

    // Key indices, row r / column c -> r*4+c.
    localparam logic [3:0] K_1    = 4'd0;
    localparam logic [3:0] K_2    = 4'd1;
    localparam logic [3:0] K_3    = 4'd2;
    localparam logic [3:0] K_A    = 4'd3;
    localparam logic [3:0] K_4    = 4'd4;
    localparam logic [3:0] K_5    = 4'd5;
    localparam logic [3:0] K_6    = 4'd6;
    localparam logic [3:0] K_B    = 4'd7;
    localparam logic [3:0] K_7    = 4'd8;
    localparam logic [3:0] K_8    = 4'd9;
    localparam logic [3:0] K_9    = 4'd10;
    localparam logic [3:0] K_C    = 4'd11;
    localparam logic [3:0] K_STAR = 4'd12;
    localparam logic [3:0] K_0    = 4'd13;
    localparam logic [3:0] K_HASH = 4'd14;
    localparam logic [3:0] K_D    = 4'd15;

    // Levels handed to the lock controller.
    typedef struct packed {
        logic [9:0] key;
        logic       open;
        logic       close;
        logic       set;
    } kp_out_t;

    // Maps a key index to its output levels; '*', '#' and 'D' drive nothing.
    function automatic kp_out_t key_decode(input logic [3:0] idx);
        kp_out_t o;
        o = '0;
        case (idx)
            K_0:     o.key[0] = 1'b1;
            K_1:     o.key[1] = 1'b1;
            K_2:     o.key[2] = 1'b1;
            K_3:     o.key[3] = 1'b1;
            K_4:     o.key[4] = 1'b1;
            K_5:     o.key[5] = 1'b1;
            K_6:     o.key[6] = 1'b1;
            K_7:     o.key[7] = 1'b1;
            K_8:     o.key[8] = 1'b1;
            K_9:     o.key[9] = 1'b1;
            K_A:     o.open   = 1'b1;
            K_B:     o.close  = 1'b1;
            K_C:     o.set    = 1'b1;
            default: o        = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/kp_debounce.sv
// Press/release debounce FSM, advanced once per completed keypad scan.
// Exposes the state and candidate the FSM takes at the coming edge so the
// parent can register its outputs in step with the state change.
module kp_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       scan_done_i,
    input  kp_class_e  class_i,
    input  logic [3:0] idx_i,
    output kp_state_e  state_next_o,
    output logic [3:0] cand_next_o
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    kp_state_e       state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic            match;

    // MULTI and a different single key both count as "not the candidate".
    assign match   = (class_i == ClsSingle) && (idx_i == cand_q);
    assign cnt_inc = cnt_q + CntOne;

    // Next-state logic; only a scan-complete strobe can move the FSM.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (scan_done_i) begin
            case (state_q)
                StIdle: begin
                    if (class_i == ClsSingle) begin
                        cand_d = idx_i;
                        if (DEBOUNCE == 1) begin
                            state_d = StHeld;
                            cnt_d   = '0;
                        end else begin
                            state_d = StPressWait;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StPressWait: begin
                    if (!match) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_inc == CntMax) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StHeld: begin
                    if (!match) begin
                        if (DEBOUNCE == 1) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            state_d = StRelWait;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StRelWait: begin
                    if (match) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else if (cnt_inc == CntMax) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state, candidate key and run counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_next_o = state_d;
    assign cand_next_o  = cand_d;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchronizer, scan snapshot,
// classification, debounce and registered decode to lock command levels.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic [3:0] COL,
    input  logic [3:0] ROW,
    output logic [9:0] KEY,
    output logic       OPEN,
    output logic       CLOSE,
    output logic       SET,
    output logic       MULTI
);

    localparam int unsigned      SlotW    = $clog2(SCAN_DIV);
    localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
    localparam logic [SlotW-1:0] SlotOne  = SlotW'(1);

    logic [3:0]       row_meta_q, row_sync_q;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [1:0]       col_q, col_d;
    logic [15:0]      snap_q, snap_d;
    logic             multi_q, multi_d;
    kp_out_t          out_q, out_d;

    logic             capture;
    logic             scan_done;
    kp_class_e        scan_class;
    logic [3:0]       scan_idx;
    kp_state_e        db_state_next;
    logic [3:0]       db_cand_next;

    // Sample late in each column's slot so the rows have settled.
    assign capture   = (slot_q == SlotLast);
    assign scan_done = capture && (col_q == 2'd3);

    // Slot counter per column, column index wraps after column 3.
    always_comb begin
        slot_d = slot_q + SlotOne;
        col_d  = col_q;
        if (capture) begin
            slot_d = '0;
            col_d  = col_q + 2'd1;
        end
    end

    // Capture the pressed (inverted) rows of the driven column into the snapshot.
    always_comb begin
        logic [1:0] r_idx;
        snap_d = snap_q;
        r_idx  = '0;
        if (capture) begin
            for (int r = 0; r < 4; r++) begin
                r_idx = 2'(r);
                snap_d[{r_idx, col_q}] = ~row_sync_q[r];
            end
        end
    end

    // Classify the snapshot including the column captured this cycle.
    always_comb begin
        int unsigned hits;
        hits     = $countones(snap_d);
        scan_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (snap_d[i]) scan_idx = 4'(i);
        end
        if (hits == 0)      scan_class = ClsNone;
        else if (hits == 1) scan_class = ClsSingle;
        else                scan_class = ClsMulti;
    end

    kp_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk_i        (CLK),
        .reset_i      (RESET),
        .scan_done_i  (scan_done),
        .class_i      (scan_class),
        .idx_i        (scan_idx),
        .state_next_o (db_state_next),
        .cand_next_o  (db_cand_next)
    );

    // Output levels follow the debounce state the FSM is entering this edge.
    always_comb begin
        multi_d = multi_q;
        if (scan_done) multi_d = (scan_class == ClsMulti);
        out_d = '0;
        if (db_state_next inside {StHeld, StRelWait}) out_d = key_decode(db_cand_next);
    end

    // All scanner state; synchronizer resets to "all released".
    always_ff @(posedge CLK) begin
        if (RESET) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            slot_q     <= '0;
            col_q      <= '0;
            snap_q     <= '0;
            multi_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;
            slot_q     <= slot_d;
            col_q      <= col_d;
            snap_q     <= snap_d;
            multi_q    <= multi_d;
            out_q      <= out_d;
        end
    end

    assign COL   = ~(4'b0001 << col_q);
    assign KEY   = out_q.key;
    assign OPEN  = out_q.open;
    assign CLOSE = out_q.close;
    assign SET   = out_q.set;
    assign MULTI = multi_q;

endmodule
